// File: rtl/calc_stream_controller.sv
// calc_stream_controller
//
// Streams operand words from SRAM over an inclusive read range. The low DATA_W bits
// of each word feed adder operand A and the next DATA_W bits feed operand B. The
// controller packs PACK = MEM_WORD_SIZE/DATA_W adder results per memory word and
// writes them back over an inclusive write range. A partial final word is written
// with its unfilled lanes zeroed.
//
// Optional feature: define CALC_SUB_EN to add mode_i, latched when a start is
// accepted, and op_sub_o, which asks the external adder to compute op_a - op_b.
//
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   mode_i, op_sub_o                    (CALC_SUB_EN only) operation select in/out
//   start_i                             begin a job; sampled in IDLE only
//   read_start_addr, read_end_addr      operand range (inclusive)
//   write_start_addr, write_end_addr    result range (inclusive)
//   busy_o, done_o, err_o               job status; done_o is a one-cycle pulse
//   read_o, r_addr_o, r_data_i          SRAM read port (data valid RD_LAT cycles on)
//   write_o, w_addr_o, w_data_o         SRAM write port
//   op_a_o, op_b_o, result_i            external adder interface
module calc_stream_controller #(
  parameter int unsigned ADDR_W        = 10,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MEM_WORD_SIZE = 64,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
`ifdef CALC_SUB_EN
  input  logic                     mode_i,
  output logic                     op_sub_o,
`endif
  input  logic                     start_i,
  input  logic [ADDR_W-1:0]        read_start_addr,
  input  logic [ADDR_W-1:0]        read_end_addr,
  input  logic [ADDR_W-1:0]        write_start_addr,
  input  logic [ADDR_W-1:0]        write_end_addr,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     read_o,
  output logic [ADDR_W-1:0]        r_addr_o,
  input  logic [MEM_WORD_SIZE-1:0] r_data_i,
  output logic                     write_o,
  output logic [ADDR_W-1:0]        w_addr_o,
  output logic [MEM_WORD_SIZE-1:0] w_data_o,
  output logic [DATA_W-1:0]        op_a_o,
  output logic [DATA_W-1:0]        op_b_o,
  input  logic [DATA_W-1:0]        result_i
);

  localparam int unsigned PACK   = MEM_WORD_SIZE / DATA_W;
  localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [2:0] {StIdle, StRead, StWait, StExec, StWrite, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        raddr_q, raddr_d, rend_q, rend_d;
  logic [ADDR_W-1:0]        waddr_q, waddr_d, wend_q, wend_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [MEM_WORD_SIZE-1:0] buf_q, buf_d;
  logic [DATA_W-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]               wcnt_q, wcnt_d;
  logic                     err_q, err_d;
  logic                     last_q, last_d;
  logic                     ranges_ok, accept;
  logic [DATA_W-1:0]        op_b_src;

  assign ranges_ok = (read_end_addr >= read_start_addr) && (write_end_addr >= write_start_addr);
  assign accept    = (state_q == StIdle) && start_i && ranges_ok;

  // With PACK == 1 there is no upper operand in the memory word.
  assign op_b_src = (PACK > 1) ? DATA_W'(r_data_i >> DATA_W) : '0;

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rend_d  = rend_q;
    waddr_d = waddr_q;
    wend_d  = wend_q;
    lane_d  = lane_q;
    buf_d   = buf_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          raddr_d = read_start_addr;
          rend_d  = read_end_addr;
          waddr_d = write_start_addr;
          wend_d  = write_end_addr;
          lane_d  = '0;
          buf_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StRead;
        end else if (start_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StRead: begin
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wcnt_q == 2'(RD_LAT - 1)) begin
          op_a_d  = r_data_i[DATA_W-1:0];
          op_b_d  = op_b_src;
          state_d = StExec;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      StExec: begin
        for (int unsigned l = 0; l < PACK; l++) begin
          if (lane_q == LANE_W'(l)) buf_d[l*DATA_W +: DATA_W] = result_i;
        end
        raddr_d = raddr_q + ADDR_W'(1);
        if ((lane_q == LANE_W'(PACK - 1)) || (raddr_q == rend_q)) begin
          last_d  = (raddr_q == rend_q);
          state_d = StWrite;
        end else begin
          lane_d  = lane_q + LANE_W'(1);
          state_d = StRead;
        end
      end
      StWrite: begin
        buf_d   = '0;
        lane_d  = '0;
        waddr_d = waddr_q + ADDR_W'(1);
        if (last_q) begin
          state_d = StDone;
        end else if (waddr_q == wend_q) begin
          // Operands remain but the result range is exhausted.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      raddr_q <= '0;
      rend_q  <= '0;
      waddr_q <= '0;
      wend_q  <= '0;
      lane_q  <= '0;
      buf_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      rend_q  <= rend_d;
      waddr_q <= waddr_d;
      wend_q  <= wend_d;
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

`ifdef CALC_SUB_EN
  logic mode_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= mode_i;
    end
  end

  assign op_sub_o = mode_q;
`else
  // Add-only build: no operation-select state.
`endif

  // Address/data outputs are gated by their strobes so idle outputs stay at zero.
  always_comb begin
    busy_o   = (state_q != StIdle);
    done_o   = (state_q == StDone);
    err_o    = err_q;
    read_o   = (state_q == StRead);
    write_o  = (state_q == StWrite);
    r_addr_o = read_o ? raddr_q : '0;
    w_addr_o = write_o ? waddr_q : '0;
    w_data_o = write_o ? buf_q : '0;
    op_a_o   = op_a_q;
    op_b_o   = op_b_q;
  end

endmodule

// File: tb/tb_calc_stream_controller.sv
// Bench for calc_stream_controller: a table of jobs checked against a scoreboard of
// expected writes, plus hand-written sequences for exact values, mid-job reset and
// a second instance with RD_LAT=3.
module tb_calc_stream_controller;
  localparam int unsigned AW   = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned MW   = 64;
  localparam int unsigned PACK = MW / DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start0, start1;
  logic [AW-1:0] rs, re, ws, we;

  logic          busy0, done0, err0, rd0, wr0;
  logic [AW-1:0] raddr0, waddr0;
  logic [MW-1:0] rdata0, wdata0;
  logic [DW-1:0] opa0, opb0, res0;

  logic          busy1, done1, err1, rd1, wr1;
  logic [AW-1:0] raddr1, waddr1;
  logic [MW-1:0] rdata1, wdata1, p1a, p1b;
  logic [DW-1:0] opa1, opb1, res1;

  logic [MW-1:0] mem [1024];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic [AW-1:0] rs, re, ws, we;
    logic          err;
    int            reads, writes;
  } vec_t;
  vec_t vecs[9];

`ifdef CALC_SUB_EN
  logic sub0, sub1;
  calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW), .RD_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(1'b0), .op_sub_o(sub0), .start_i(start0),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .busy_o(busy0), .done_o(done0), .err_o(err0), .read_o(rd0), .r_addr_o(raddr0),
    .r_data_i(rdata0), .write_o(wr0), .w_addr_o(waddr0), .w_data_o(wdata0),
    .op_a_o(opa0), .op_b_o(opb0), .result_i(res0));
  calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW), .RD_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(1'b0), .op_sub_o(sub1), .start_i(start1),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .read_o(rd1), .r_addr_o(raddr1),
    .r_data_i(rdata1), .write_o(wr1), .w_addr_o(waddr1), .w_data_o(wdata1),
    .op_a_o(opa1), .op_b_o(opb1), .result_i(res1));
  assign res0 = sub0 ? opa0 - opb0 : opa0 + opb0;
  assign res1 = sub1 ? opa1 - opb1 : opa1 + opb1;
`else
  calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW), .RD_LAT(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start0),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .busy_o(busy0), .done_o(done0), .err_o(err0), .read_o(rd0), .r_addr_o(raddr0),
    .r_data_i(rdata0), .write_o(wr0), .w_addr_o(waddr0), .w_data_o(wdata0),
    .op_a_o(opa0), .op_b_o(opb0), .result_i(res0));
  calc_stream_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_WORD_SIZE(MW), .RD_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1),
    .read_start_addr(rs), .read_end_addr(re), .write_start_addr(ws), .write_end_addr(we),
    .busy_o(busy1), .done_o(done1), .err_o(err1), .read_o(rd1), .r_addr_o(raddr1),
    .r_data_i(rdata1), .write_o(wr1), .w_addr_o(waddr1), .w_data_o(wdata1),
    .op_a_o(opa1), .op_b_o(opb1), .result_i(res1));
  assign res0 = opa0 + opb0;
  assign res1 = opa1 + opb1;
`endif

  // SRAM models: data valid 1 and 3 cycles after the read strobe is sampled.
  always @(posedge clk) begin
    rdata0 <= rd0 ? mem[raddr0] : '0;
    p1a    <= rd1 ? mem[raddr1] : '0;
    p1b    <= p1a;
    rdata1 <= p1b;
  end

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: expected write sequence of a valid job from the memory image.
  task automatic push_model(input int a_rs, input int a_re, input int a_ws, input int a_we);
    int n, words, allowed, idx;
    wr_t w;
    n       = a_re - a_rs + 1;
    words   = (n + PACK - 1) / PACK;
    allowed = a_we - a_ws + 1;
    if (words > allowed) words = allowed;
    for (int k = 0; k < words; k++) begin
      w.addr = AW'(a_ws + k);
      w.data = '0;
      for (int j = 0; j < PACK; j++) begin
        idx = a_rs + k * PACK + j;
        if (idx <= a_re) w.data[j*DW +: DW] = mem[idx][DW-1:0] + mem[idx][2*DW-1:DW];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic run_job(input string tag, input logic [AW-1:0] a_rs, input logic [AW-1:0] a_re,
                         input logic [AW-1:0] a_ws, input logic [AW-1:0] a_we,
                         input logic e_err, input int e_reads, input int e_writes);
    int  nrd, nwr, first_rd, first_wr, done_cyc, min_ops;
    bit  bad_rd, overlap;
    wr_t e;
    nrd = 0; nwr = 0; first_rd = -1; first_wr = -1; done_cyc = -1;
    bad_rd = 0; overlap = 0;
    rs = a_rs; re = a_re; ws = a_ws; we = a_we;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (rd0 && wr0) overlap = 1;
      if (rd0) begin
        if (first_rd < 0) first_rd = cyc;
        nrd++;
        if (raddr0 < a_rs || raddr0 > a_re) bad_rd = 1;
      end
      if (wr0) begin
        if (first_wr < 0) first_wr = cyc;
        nwr++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s unexpected write: got addr %0h data %0h expected none", tag, waddr0,
                   wdata0);
        end else begin
          e = exp_q.pop_front();
          check({tag, " w_addr"}, MW'(waddr0), MW'(e.addr));
          check({tag, " w_data"}, wdata0, e.data);
        end
      end
      if (done0) begin
        done_cyc = cyc;
        break;
      end
      check({tag, " busy"}, MW'(busy0), 1);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL %s timeout: got no done_o expected done_o within 400 cycles", tag);
    end
    check({tag, " err"}, MW'(err0), MW'(e_err));
    check({tag, " reads"}, MW'(nrd), MW'(e_reads));
    check({tag, " writes"}, MW'(nwr), MW'(e_writes));
    check({tag, " read_range"}, MW'(bad_rd), 0);
    check({tag, " rd_wr_overlap"}, MW'(overlap), 0);
    check({tag, " pending"}, MW'(exp_q.size()), 0);
    if (e_reads == 0) begin
      check({tag, " done_latency"}, MW'(done_cyc), 0);
    end else begin
      // Each operand costs READ + WAIT + EXEC before the first word is written.
      min_ops = (e_reads < PACK) ? e_reads : PACK;
      check({tag, " first_write_latency"}, MW'(first_wr - first_rd), MW'(min_ops * 3));
    end
    exp_q.delete();
    @(posedge clk); #1;
    check({tag, " done_pulse"}, MW'(done0), 0);
    check({tag, " idle"}, MW'(busy0), 0);
    check({tag, " err_held"}, MW'(err0), MW'(e_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, MW'(busy0), 0);
    check({tag, " done"}, MW'(done0), 0);
    check({tag, " err"}, MW'(err0), 0);
    check({tag, " strobes"}, MW'({rd0, wr0}), 0);
    check({tag, " addrs"}, MW'({raddr0, waddr0}), 0);
    check({tag, " w_data"}, wdata0, 0);
    check({tag, " ops"}, {opa0, opb0}, 0);
  endtask

  initial begin
    logic [DW-1:0] hist [128];
    int  rdc[$];
    int  wr_cnt, wr_cyc, found;
    logic [AW-1:0] wa;
    logic [MW-1:0] wd;
    logic [DW-1:0] exp_a [2];

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    rs = '0; re = '0; ws = '0; we = '0;
    for (int i = 0; i < 1024; i++) mem[i] = {$urandom(), $urandom()};

    vecs[0] = '{10'd0,    10'd0,    10'd16,   10'd16,   1'b0, 1, 1};
    vecs[1] = '{10'd0,    10'd3,    10'd16,   10'd17,   1'b0, 4, 2};
    vecs[2] = '{10'd0,    10'd5,    10'd16,   10'd16,   1'b1, 2, 1};
    vecs[3] = '{10'd8,    10'd4,    10'd16,   10'd16,   1'b1, 0, 0};
    vecs[4] = '{10'd3,    10'd3,    10'd20,   10'd19,   1'b1, 0, 0};
    vecs[5] = '{10'd10,   10'd14,   10'd30,   10'd32,   1'b0, 5, 3};
    vecs[6] = '{10'd10,   10'd14,   10'd30,   10'd31,   1'b1, 4, 2};
    vecs[7] = '{10'd1023, 10'd1023, 10'd1023, 10'd1023, 1'b0, 1, 1};
    vecs[8] = '{10'd100,  10'd103,  10'd200,  10'd205,  1'b0, 4, 2};

    #22;
    check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].re >= vecs[v].rs && vecs[v].we >= vecs[v].ws)
        push_model(int'(vecs[v].rs), int'(vecs[v].re), int'(vecs[v].ws), int'(vecs[v].we));
      run_job($sformatf("vec%0d", v), vecs[v].rs, vecs[v].re, vecs[v].ws, vecs[v].we,
              vecs[v].err, vecs[v].reads, vecs[v].writes);
    end

    // Single word with exact values: 3 + 5 in lane 0, lane 1 zero.
    mem[0] = {32'd5, 32'd3};
    exp_q.push_back('{10'd16, {32'd0, 32'd8}});
    run_job("single", 10'd0, 10'd0, 10'd16, 10'd16, 1'b0, 1, 1);

    // Full pack: sums 1..4 over two words.
    for (int i = 0; i < 4; i++) mem[i] = {32'd0, 32'(i + 1)};
    exp_q.push_back('{10'd16, {32'd2, 32'd1}});
    exp_q.push_back('{10'd17, {32'd4, 32'd3}});
    run_job("fullpack", 10'd0, 10'd3, 10'd16, 10'd17, 1'b0, 4, 2);

    // Reset during WAIT of the second operand.
    rs = 10'd0; re = 10'd3; ws = 10'd16; we = 10'd17;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 50 && found < 2; cyc++) begin
      if (rd0) found++;
      if (found < 2) begin
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (found < 2) begin
      n_bad++;
      $display("FAIL midreset setup: got %0d reads expected 2", found);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push_model(0, 3, 16, 17);
    run_job("after_reset", 10'd0, 10'd3, 10'd16, 10'd17, 1'b0, 4, 2);

    // RD_LAT=3 instance: operands latched on the last WAIT edge, same results.
    mem[0] = {32'd20, 32'd10};
    mem[1] = {32'd40, 32'd30};
    exp_a[0] = 32'd10;
    exp_a[1] = 32'd30;
    rs = 10'd0; re = 10'd1; ws = 10'd16; we = 10'd16;
    wr_cnt = 0; wr_cyc = -1; wa = '0; wd = '0; found = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int cyc = 0; cyc < 128; cyc++) begin
      hist[cyc] = opa1;
      if (rd1) rdc.push_back(cyc);
      if (wr1) begin
        wr_cnt++;
        wr_cyc = cyc;
        wa = waddr1;
        wd = wdata1;
      end
      if (done1) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("lat3 done", MW'(found), 1);
    check("lat3 reads", MW'(rdc.size()), 2);
    if (rdc.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("lat3 op_a_early%0d", k), MW'(hist[rdc[k] + 3] == exp_a[k]), 0);
        check($sformatf("lat3 op_a%0d", k), MW'(hist[rdc[k] + 4]), MW'(exp_a[k]));
      end
      check("lat3 first_write_latency", MW'(wr_cyc - rdc[0]), 10);
    end
    check("lat3 writes", MW'(wr_cnt), 1);
    check("lat3 w_addr", MW'(wa), 16);
    check("lat3 w_data", wd, {32'd70, 32'd30});
    check("lat3 err", MW'(err1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
